// File: rtl/vga_sync_gen_if.sv
// Signal bundle between the VGA timing generator and the downstream pixel renderer.
// The master drives timing; the slave (renderer / connector) only observes it.
interface vga_sync_gen_if;
    logic       pixel_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       h_sync;
    logic       v_sync;
    logic       frame_start;

    modport master (
        output pixel_tick,
        output pixel_x,
        output pixel_y,
        output video_on,
        output h_sync,
        output v_sync,
        output frame_start
    );

    modport slave (
        input pixel_tick,
        input pixel_x,
        input pixel_y,
        input video_on,
        input h_sync,
        input v_sync,
        input frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the system clock to the pixel rate and produces
// pixel coordinates, sync pulses, video_on and a frame-start strobe.
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C     = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C     = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              tick_q, tick_d;
    logic              frame_q, frame_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              von_q, von_d;

    logic advance;
    logic x_wrap;
    logic y_wrap;

    assign advance = (tick_cnt_q == TICK_LAST);
    assign x_wrap  = (x_q == H_LAST);
    assign y_wrap  = (y_q == V_LAST);

    always_comb begin
        tick_cnt_d = advance ? '0 : TICK_W'(tick_cnt_q + 1'b1);
        tick_d     = advance;
        frame_d    = advance && x_wrap && y_wrap;
        x_d        = x_q;
        y_d        = y_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        von_d      = von_q;

        // Counters and decode move together on the pixel tick, so the sync and
        // video_on outputs always describe the coordinate being presented.
        if (advance) begin
            x_d = x_wrap ? 10'd0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = y_wrap ? 10'd0 : y_q + 10'd1;
            end
            hs_d  = ((x_d >= H_SYNC_BEG) && (x_d <= H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
            vs_d  = ((y_d >= V_SYNC_BEG) && (y_d <= V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
            von_d = (x_d < H_VIS_C) && (y_d < V_VIS_C);
        end
    end

    // video_on only updates on a tick, which keeps it low from reset to the first tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            tick_q     <= 1'b0;
            frame_q    <= 1'b0;
            hs_q       <= ~SYNC_POL;
            vs_q       <= ~SYNC_POL;
            von_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tick_q     <= tick_d;
            frame_q    <= frame_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            von_q      <= von_d;
        end
    end

    assign vga.pixel_tick  = tick_q;
    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.video_on    = von_q;
    assign vga.h_sync      = hs_q;
    assign vga.v_sync      = vs_q;
    assign vga.frame_start = frame_q;
endmodule
